// File: rtl/flap_debounce_if.sv
// Player-button / flap bus between the input front end and the debouncer.
// The front end is the master (drives the button level and the game-running
// qualifier); the debouncer is the slave (returns the flap pulse and status).
interface flap_debounce_if;
  logic       btn_sync;
  logic       enable;
  logic       flap;
  logic       btn_level;
  logic [7:0] flap_count;

  modport master (
    output btn_sync, enable,
    input  flap, btn_level, flap_count
  );

  modport slave (
    input  btn_sync, enable,
    output flap, btn_level, flap_count
  );
endinterface

// File: rtl/flap_debounce.sv
// Button debouncer and flap pulse generator.
// A level change is accepted after DEBOUNCE_CYCLES identical samples; each
// accepted press issues one flap pulse, gated by enable and a cooldown window.
// Optional feature macro: FLAP_AUTOREPEAT_EN -- while the button is held, a
// repeat counter requests another flap every REPEAT_CYCLES cycles.
module flap_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8,
  parameter int unsigned REPEAT_CYCLES   = 10
) (
  input  logic           clk,
  input  logic           reset,
  flap_debounce_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONFIRM_HI, HELD, CONFIRM_LO} state_t;

  localparam int CW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CDW = $clog2(COOLDOWN_CYCLES) + 1;
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_CYCLES);

  // Reject out-of-range configurations at elaboration.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end
  if (COOLDOWN_CYCLES > 255) begin : g_bad_cd
    $error("COOLDOWN_CYCLES out of range 0..255");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_bad_rpt
    $error("REPEAT_CYCLES out of range 1..255");
  end

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [CDW-1:0] cool, cool_n;
  logic           press;      // HELD entered from the low side this edge
  logic           fire;       // a flap is requested this edge
  logic           cool_ok;
  logic           flap_n;
  logic           level_n;
  logic           flap_q, level_q;
  logic [7:0]     count_q;

`ifdef FLAP_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt, rpt_n;
  logic          rpt_req;
`endif

  // Debounce FSM next state; cnt counts consecutive samples that disagree
  // with the accepted level, and is zero in IDLE and HELD.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press   = 1'b0;
    case (state)
      IDLE, CONFIRM_HI: begin
        if (bus.btn_sync) begin
          if (cnt == DB_LAST) begin
            state_n = HELD;
            cnt_n   = '0;
            press   = 1'b1;
          end else begin
            state_n = CONFIRM_HI;
            cnt_n   = cnt + CW'(1);
          end
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      HELD, CONFIRM_LO: begin
        if (!bus.btn_sync) begin
          if (cnt == DB_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = CONFIRM_LO;
            cnt_n   = cnt + CW'(1);
          end
        end else begin
          // A high sample while confirming low is a glitch: back to HELD
          // without a new press.
          state_n = HELD;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef FLAP_AUTOREPEAT_EN
  // Auto-repeat: restart on each new press, tick while held, request a flap
  // and restart every REPEAT_CYCLES cycles.
  always_comb begin
    rpt_n   = rpt;
    rpt_req = 1'b0;
    if (press) begin
      rpt_n = '0;
    end else if (state == HELD) begin
      if (rpt == RPT_LAST) begin
        rpt_n   = '0;
        rpt_req = 1'b1;
      end else begin
        rpt_n = rpt + RW'(1);
      end
    end
  end
`endif

  // Flap gating and cooldown. The window counts as closed when the cooldown
  // register is at 1 or 0, so a press landing on the edge where it reaches
  // 0 still flaps (flaps are COOLDOWN_CYCLES edges apart at minimum).
  always_comb begin
    fire = press;
`ifdef FLAP_AUTOREPEAT_EN
    if (rpt_req) fire = 1'b1;
`endif
    cool_ok = (cool <= CDW'(1));
    flap_n  = fire & bus.enable & cool_ok;
    level_n = (state_n == HELD) || (state_n == CONFIRM_LO);
    cool_n  = cool;
    if (flap_n)
      cool_n = CD_LOAD;
    else if (cool != '0)
      cool_n = cool - CDW'(1);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cool    <= '0;
      flap_q  <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
`ifdef FLAP_AUTOREPEAT_EN
      rpt     <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cool    <= cool_n;
      flap_q  <= flap_n;
      level_q <= level_n;
      count_q <= count_q + {7'd0, flap_n};
`ifdef FLAP_AUTOREPEAT_EN
      rpt     <= rpt_n;
`endif
    end
  end

  assign bus.flap       = flap_q;
  assign bus.btn_level  = level_q;
  assign bus.flap_count = count_q;

endmodule

// File: tb/tb_flap_debounce.sv
// Directed bench for flap_debounce: dut0 uses default parameters, dut1 uses
// DEBOUNCE_CYCLES=1 to reach tight press spacing against the cooldown window.
module tb_flap_debounce;

`ifdef FLAP_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nf0 = 0;
  int   nf1 = 0;

  always #5 clk = ~clk;

  flap_debounce_if if0();
  flap_debounce_if if1();

  flap_debounce dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  flap_debounce #(
    .DEBOUNCE_CYCLES (1),
    .COOLDOWN_CYCLES (8),
    .REPEAT_CYCLES   (10)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  // One clock edge; outputs are sampled 1 ns after it and inputs set there.
  task automatic tick();
    @(posedge clk);
    #1;
    nf0 += int'(if0.flap);
    nf1 += int'(if1.flap);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if0.btn_sync = 1'b0; if0.enable = 1'b1;
    if1.btn_sync = 1'b0; if1.enable = 1'b1;
    ticks(2);
    n_cmp++; if (if0.flap !== 1'b0) begin n_bad++; $display("FAIL reset_flap got %b want 0", if0.flap); end
    n_cmp++; if (if0.btn_level !== 1'b0) begin n_bad++; $display("FAIL reset_level got %b want 0", if0.btn_level); end
    n_cmp++; if (if0.flap_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", if0.flap_count); end
    n_cmp++; if (if1.flap_count !== 8'd0) begin n_bad++; $display("FAIL reset_count1 got %0d want 0", if1.flap_count); end
    reset = 1'b1;
    ticks(2);
  endtask

  task automatic test_basic();
    if0.btn_sync = 1'b1;
    ticks(3);
    n_cmp++; if ({if0.flap, if0.btn_level} !== 2'b00) begin n_bad++; $display("FAIL basic_pre got %b want 00", {if0.flap, if0.btn_level}); end
    tick();
    n_cmp++; if ({if0.flap, if0.btn_level} !== 2'b11) begin n_bad++; $display("FAIL basic_flap got %b want 11", {if0.flap, if0.btn_level}); end
    n_cmp++; if (if0.flap_count !== 8'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", if0.flap_count); end
    tick();
    n_cmp++; if ({if0.flap, if0.btn_level} !== 2'b01) begin n_bad++; $display("FAIL basic_one_cycle got %b want 01", {if0.flap, if0.btn_level}); end
    if0.btn_sync = 1'b0;
    ticks(3);
    n_cmp++; if (if0.btn_level !== 1'b1) begin n_bad++; $display("FAIL basic_release_pre got %b want 1", if0.btn_level); end
    tick();
    n_cmp++; if (if0.btn_level !== 1'b0) begin n_bad++; $display("FAIL basic_release got %b want 0", if0.btn_level); end
    ticks(10);
  endtask

  task automatic test_glitch();
    logic [7:0] pat;
    pat = 8'b1110_1111;  // applied MSB first
    nf0 = 0;
    for (int i = 7; i >= 0; i--) begin
      if0.btn_sync = pat[i];
      tick();
      if (i == 1) begin
        n_cmp++; if ({if0.flap, if0.btn_level} !== 2'b00) begin n_bad++; $display("FAIL glitch_pre got %b want 00", {if0.flap, if0.btn_level}); end
      end
    end
    n_cmp++; if ({if0.flap, if0.btn_level} !== 2'b11) begin n_bad++; $display("FAIL glitch_flap got %b want 11", {if0.flap, if0.btn_level}); end
    n_cmp++; if (nf0 !== 1) begin n_bad++; $display("FAIL glitch_nflaps got %0d want 1", nf0); end
    n_cmp++; if (if0.flap_count !== 8'd2) begin n_bad++; $display("FAIL glitch_count got %0d want 2", if0.flap_count); end
    if0.btn_sync = 1'b0;
    ticks(14);
  endtask

  task automatic test_enable();
    nf0 = 0;
    if0.enable = 1'b0;
    if0.btn_sync = 1'b1;
    ticks(4);
    n_cmp++; if ({if0.flap, if0.btn_level} !== 2'b01) begin n_bad++; $display("FAIL enable_off got %b want 01", {if0.flap, if0.btn_level}); end
    if0.enable = 1'b1;
    ticks(5);
    n_cmp++; if (nf0 !== 0) begin n_bad++; $display("FAIL enable_rise_nflaps got %0d want 0", nf0); end
    n_cmp++; if (if0.flap_count !== 8'd2) begin n_bad++; $display("FAIL enable_count got %0d want 2", if0.flap_count); end
    if0.btn_sync = 1'b0;
    ticks(6);
  endtask

  task automatic test_reset_mid();
    nf0 = 0;
    if0.btn_sync = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
    n_cmp++; if ({if0.flap, if0.btn_level, if0.flap_count} !== 10'd0) begin n_bad++; $display("FAIL rstmid_outputs got %b want 0", {if0.flap, if0.btn_level, if0.flap_count}); end
    reset = 1'b1;
    ticks(3);
    n_cmp++; if ({nf0, if0.btn_level} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL rstmid_pre got flaps %0d level %b want 0 0", nf0, if0.btn_level); end
    tick();
    n_cmp++; if ({if0.flap, if0.flap_count} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL rstmid_flap got %b/%0d want 1/1", if0.flap, if0.flap_count); end
    if0.btn_sync = 1'b0;
    ticks(14);
  endtask

  task automatic test_cooldown();
    if1.btn_sync = 1'b1; tick();     // E0
    n_cmp++; if ({if1.flap, if1.flap_count} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL cool_first got %b/%0d want 1/1", if1.flap, if1.flap_count); end
    if1.btn_sync = 1'b0; ticks(4);   // E0+1..E0+4
    if1.btn_sync = 1'b1; tick();     // E0+5: inside cooldown
    n_cmp++; if ({if1.flap, if1.btn_level, if1.flap_count} !== {1'b0, 1'b1, 8'd1}) begin n_bad++; $display("FAIL cool_drop got %b/%b/%0d want 0/1/1", if1.flap, if1.btn_level, if1.flap_count); end
    if1.btn_sync = 1'b0; ticks(2);   // E0+6, E0+7
    if1.btn_sync = 1'b1; tick();     // E0+8: cooldown just expired
    n_cmp++; if ({if1.flap, if1.flap_count} !== {1'b1, 8'd2}) begin n_bad++; $display("FAIL cool_edge got %b/%0d want 1/2", if1.flap, if1.flap_count); end
    if1.btn_sync = 1'b0; ticks(9);
  endtask

  task automatic test_wrap();
    nf1 = 0;
    for (int k = 1; k <= 254; k++) begin
      if1.btn_sync = 1'b1; tick();
      if1.btn_sync = 1'b0; ticks(8);
      if (k == 253) begin
        n_cmp++; if (if1.flap_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255 got %0d want 255", if1.flap_count); end
      end
    end
    n_cmp++; if (if1.flap_count !== 8'd0) begin n_bad++; $display("FAIL wrap_0 got %0d want 0", if1.flap_count); end
    n_cmp++; if (nf1 !== 254) begin n_bad++; $display("FAIL wrap_nflaps got %0d want 254", nf1); end
  endtask

  task automatic test_hold();
    logic exp_f;
    nf0 = 0;
    if0.btn_sync = 1'b1;
    ticks(4);
    n_cmp++; if (if0.flap !== 1'b1) begin n_bad++; $display("FAIL hold_entry got %b want 1", if0.flap); end
    for (int i = 1; i <= 35; i++) begin
      tick();
      exp_f = AUTOREP && (i % 10 == 0);
      n_cmp++; if (if0.flap !== exp_f) begin n_bad++; $display("FAIL hold_flap_%0d got %b want %b", i, if0.flap, exp_f); end
    end
    n_cmp++; if (nf0 !== (AUTOREP ? 4 : 1)) begin n_bad++; $display("FAIL hold_nflaps got %0d want %0d", nf0, AUTOREP ? 4 : 1); end
    n_cmp++; if (if0.flap_count !== (AUTOREP ? 8'd5 : 8'd2)) begin n_bad++; $display("FAIL hold_count got %0d want %0d", if0.flap_count, AUTOREP ? 5 : 2); end
    if0.btn_sync = 1'b0;
    ticks(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_enable();
    test_reset_mid();
    test_cooldown();
    test_wrap();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flap_debounce.md
FLAP_DEBOUNCE -- requirements
Module: flap_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL give the consecutive identical samples needed to accept a level change (legal range 1..255).
REQ-002 Parameter COOLDOWN_CYCLES, default 8, SHALL give the minimum cycles after a flap before another flap may issue (legal range 0..255).
REQ-003 Parameter REPEAT_CYCLES, default 10, SHALL give the auto-repeat interval while held (legal range 1..255); it is used only when FLAP_AUTOREPEAT_EN is defined.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-006 btn_sync  input  1  SHALL be the already-synchronized player button level from the upstream two-flop synchronizer.
REQ-007 enable  input  1  SHALL be the game-running qualifier; flaps issue only while enable=1.
REQ-008 flap  output  1  SHALL be the registered one-cycle flap pulse to the bird physics.
REQ-009 btn_level  output  1  SHALL be the registered debounced button level.
REQ-010 flap_count  output  8  SHALL be the registered count of issued flaps.

Function
REQ-011 The FSM SHALL have states IDLE (level low), CONFIRM_HI, HELD (level high) and CONFIRM_LO.
REQ-012 IDLE SHALL go to CONFIRM_HI when btn_sync=1, with the stability counter set to 1.
REQ-013 In CONFIRM_HI, btn_sync=1 SHALL increment the counter; btn_sync=0 SHALL return to IDLE with the counter cleared.
REQ-014 On the edge of the DEBOUNCE_CYCLES-th consecutive high sample, the FSM SHALL enter HELD and btn_level SHALL rise; with DEBOUNCE_CYCLES=1 this happens on the first high sample.
REQ-015 HELD to CONFIRM_LO to IDLE SHALL be the mirror of REQ-012..014 for low samples; any high sample in CONFIRM_LO SHALL return to HELD.
REQ-016 On the edge of the HELD entry, flap SHALL be 1 for exactly the next cycle, but only if enable=1 and cooldown=0 on that edge; otherwise the press SHALL be dropped (not queued).
REQ-017 The cooldown counter SHALL load COOLDOWN_CYCLES on every flap, decrement by 1 per cycle while nonzero, and hold at 0.
REQ-018 A press confirmed exactly on the edge where cooldown reaches 0 SHALL see cooldown=0 and issue a flap.
REQ-019 enable=0 SHALL suppress flap only; the FSM, btn_level and cooldown SHALL keep running.
REQ-020 enable rising while in HELD SHALL NOT produce a flap; flaps are edge-triggered only.
REQ-021 flap_count SHALL increment by 1 on each flap and wrap from 255 to 0.
REQ-022 Counters SHALL be sized to $clog2 of their parameter plus 1 and SHALL never overflow.

Reset
REQ-023 With reset=0 on a clock edge, the state SHALL become IDLE and the stability, cooldown and repeat counters SHALL become 0.
REQ-024 With reset=0 on a clock edge, flap, btn_level and flap_count SHALL all become 0.
REQ-025 Reset asserted mid-confirm or mid-cooldown SHALL abandon that operation with no flap issued.
REQ-026 After reset release, a button already held high SHALL need the full DEBOUNCE_CYCLES high samples before it is accepted.

Configuration
REQ-027 With macro FLAP_AUTOREPEAT_EN defined, a repeat counter SHALL clear on HELD entry and count while in HELD.
REQ-028 With FLAP_AUTOREPEAT_EN defined, each time the repeat counter reaches REPEAT_CYCLES it SHALL clear and request a flap, which is subject to REQ-016 gating and REQ-017 cooldown.
REQ-029 With FLAP_AUTOREPEAT_EN undefined, the repeat counter and its logic SHALL be absent and a held button SHALL yield exactly one flap.

Verification
REQ-030 Defaults, enable=1, btn_sync 0 to 1 held: SHALL give flap=1 for one cycle after the 4th high sample, btn_level=1, flap_count=1.
REQ-031 Pulse train 1,1,1,0,1,1,1,1: SHALL give one flap after the final 4 highs and none for the first 3-high glitch.
REQ-032 Two presses, second confirmed 5 cycles after the first flap (cooldown 8): SHALL drop the second (flap_count=1); a press 8 cycles after SHALL flap (flap_count=2).
REQ-033 enable=0 during a press, then enable=1 while still held: SHALL give no flap while btn_level=1.
REQ-034 Reset=0 on the 3rd confirming high sample: SHALL give all outputs 0 next cycle and no flap until 4 fresh high samples.
REQ-035 With FLAP_AUTOREPEAT_EN, held 35 cycles after confirm: SHALL give flaps at HELD entry +10, +20 and +30 (4 total); 256 flaps SHALL wrap flap_count to 0.
